// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, state/alu_op enums and mux encodings for the multicycle control FSM
package mc_ctrl_pkg;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP, S_FAULT, S_TRAP
  } state_e;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_FUNCT = 3'd2,
    ALU_AND = 3'd3, ALU_OR = 3'd4, ALU_SLT = 3'd5
  } aluop_e;
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU      = 2'b00;
  localparam logic [1:0] PC_ALUOUT   = 2'b01;
  localparam logic [1:0] PC_JUMP     = 2'b10;
  localparam logic [1:0] PC_EXC      = 2'b11;
  function automatic logic is_wait(state_e s);
    return s inside {S_FETCH, S_MEMRD, S_MEMWR};
  endfunction
endpackage

// File: rtl/mc_mem_watchdog.sv
// mc_mem_watchdog: counts stalled memory cycles and flags expiry at TIMEOUT (0 = never)
module mc_mem_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : waiting ? cnt_q + 1'b1 : cnt_q;
  assign expired = (TIMEOUT != 0) && waiting && (cnt_q == CW'(TIMEOUT - 1));
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multicycle MIPS main control with memory watchdog; ILLEGAL_TRAP_EN adds illegal-opcode trap
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                branch,
  output logic                branch_ne,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic                mem_to_reg,
  output logic                reg_dest,
  output logic                zero_ext,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                bus_err,
  output logic                instr_done
`ifdef ILLEGAL_TRAP_EN
  , output logic              illegal_op
`endif
);
`ifdef ILLEGAL_TRAP_EN
  localparam state_e S_BAD = S_TRAP;
`else
  localparam state_e S_BAD = S_FETCH;
`endif
  state_e state_q, state_d;
  aluop_e op;
  logic expired;
  logic is_lw, is_sw, is_rt, is_beq, is_bne, is_addi, is_andi, is_ori, is_slti, is_j, is_imm;
  assign is_lw   = opcode == OPCODE_W'(OP_LW);
  assign is_sw   = opcode == OPCODE_W'(OP_SW);
  assign is_rt   = opcode == OPCODE_W'(OP_RTYPE);
  assign is_beq  = opcode == OPCODE_W'(OP_BEQ);
  assign is_bne  = opcode == OPCODE_W'(OP_BNE);
  assign is_addi = opcode == OPCODE_W'(OP_ADDI);
  assign is_andi = opcode == OPCODE_W'(OP_ANDI);
  assign is_ori  = opcode == OPCODE_W'(OP_ORI);
  assign is_slti = opcode == OPCODE_W'(OP_SLTI);
  assign is_j    = opcode == OPCODE_W'(OP_J);
  assign is_imm  = is_addi || is_andi || is_ori || is_slti;
  assign alu_op  = ALUOP_W'(op);
  mc_mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_d != state_q),
    .waiting (is_wait(state_q) && !mem_ready),
    .expired (expired)
  );
  // Outputs are Mealy on mem_ready and forced low while reset is held.
  always_comb begin
    state_d = state_q;
    {mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write, branch, branch_ne,
     alu_src_a, mem_to_reg, reg_dest, zero_ext, bus_err, instr_done} = '0;
    alu_src_b = SRCB_RT;
    pc_src = PC_ALU;
    op = ALU_ADD;
`ifdef ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write = mem_ready;
          pc_write = mem_ready;
          state_d = mem_ready ? S_DECODE : expired ? S_FAULT : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          state_d = (is_lw || is_sw) ? S_MEMADR : is_rt ? S_EXEC :
                    (is_beq || is_bne) ? S_BRANCH : is_imm ? S_IMMEX :
                    is_j ? S_JUMP : S_BAD;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d = is_lw ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          i_or_d = 1'b1;
          state_d = mem_ready ? S_MEMWB : expired ? S_FAULT : S_MEMRD;
        end
        S_MEMWB: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d = S_FETCH;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_write = 1'b1;
          i_or_d = 1'b1;
          instr_done = mem_ready;
          state_d = mem_ready ? S_FETCH : expired ? S_FAULT : S_MEMWR;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          op = ALU_FUNCT;
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dest = 1'b1;
          instr_done = 1'b1;
          state_d = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          op = ALU_SUB;
          pc_src = PC_ALUOUT;
          instr_done = 1'b1;
          branch = is_beq;
          branch_ne = is_bne;
          state_d = S_FETCH;
        end
        S_IMMEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          op = is_andi ? ALU_AND : is_ori ? ALU_OR : is_slti ? ALU_SLT : ALU_ADD;
          zero_ext = is_andi || is_ori;
          state_d = S_IMMWB;
        end
        S_IMMWB: begin
          reg_write = 1'b1;
          instr_done = 1'b1;
          zero_ext = is_andi || is_ori;
          state_d = S_FETCH;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src = PC_JUMP;
          instr_done = 1'b1;
          state_d = S_FETCH;
        end
        S_FAULT: begin
          bus_err = 1'b1;
          pc_write = 1'b1;
          pc_src = PC_EXC;
          state_d = S_FETCH;
        end
        S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
          illegal_op = 1'b1;
`endif
          pc_write = 1'b1;
          pc_src = PC_EXC;
          instr_done = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) state_q <= reset ? S_FETCH : state_d;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: random instruction streams checked cycle-by-cycle against an instruction-level model
module tb_multicycle_ctrl_fsm;
  localparam int TO = 4;
  typedef struct packed {
    logic mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write, branch, branch_ne, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic mem_to_reg, reg_dest, zero_ext;
    logic [2:0] alu_op;
    logic bus_err, instr_done, illegal;
  } ctl_t;
  typedef struct packed {logic rdy; ctl_t c;} step_t;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic [5:0] opcode = 6'h0;
  logic mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write, branch, branch_ne, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic mem_to_reg, reg_dest, zero_ext, bus_err, instr_done, illegal_w;
  logic [2:0] alu_op;
  ctl_t got;
  step_t q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  multicycle_ctrl_fsm #(.OPCODE_W(6), .ALUOP_W(3), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .branch(branch), .branch_ne(branch_ne),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .mem_to_reg(mem_to_reg),
    .reg_dest(reg_dest), .zero_ext(zero_ext), .alu_op(alu_op), .bus_err(bus_err),
    .instr_done(instr_done)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_w)
`endif
  );
`ifndef ILLEGAL_TRAP_EN
  assign illegal_w = 1'b0;
`endif
  assign got = {mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write, branch, branch_ne,
                alu_src_a, alu_src_b, pc_src, mem_to_reg, reg_dest, zero_ext, alu_op,
                bus_err, instr_done, illegal_w};
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask
  task automatic push(logic r, ctl_t c);
    step_t s;
    s.rdy = r;
    s.c = c;
    q.push_back(s);
  endtask
  // A memory phase: stall rows, then either the completing row or a bus fault.
  task automatic add_mem(ctl_t w, ctl_t done, int waits, output bit faulted);
    ctl_t f = '0;
    faulted = (waits >= TO);
    for (int i = 0; i < (faulted ? TO : waits); i++) push(1'b0, w);
    if (faulted) begin
      f.bus_err = 1'b1;
      f.pc_write = 1'b1;
      f.pc_src = 2'b11;
      push(1'($urandom), f);
    end else push(1'b1, done);
  endtask
  task automatic build(logic [5:0] op, int fw, int mw);
    ctl_t w, d, c;
    bit flt;
    q.delete();
    w = '0;
    w.mem_req = 1'b1;
    w.alu_src_b = 2'b01;
    d = w;
    d.ir_write = 1'b1;
    d.pc_write = 1'b1;
    add_mem(w, d, fw, flt);
    if (flt) return;
    c = '0;
    c.alu_src_b = 2'b11;
    push(1'($urandom), c);
    c = '0;
    if (op == 6'b100011 || op == 6'b101011) begin
      c.alu_src_a = 1'b1;
      c.alu_src_b = 2'b10;
      push(1'($urandom), c);
      w = '0;
      w.mem_req = 1'b1;
      w.i_or_d = 1'b1;
      w.mem_write = (op == 6'b101011);
      d = w;
      d.instr_done = (op == 6'b101011);
      add_mem(w, d, mw, flt);
      if (flt || op == 6'b101011) return;
      c = '0;
      c.reg_write = 1'b1;
      c.mem_to_reg = 1'b1;
      c.instr_done = 1'b1;
      push(1'($urandom), c);
    end else if (op == 6'b000000) begin
      c.alu_src_a = 1'b1;
      c.alu_op = 3'd2;
      push(1'($urandom), c);
      c = '0;
      c.reg_write = 1'b1;
      c.reg_dest = 1'b1;
      c.instr_done = 1'b1;
      push(1'($urandom), c);
    end else if (op == 6'b000100 || op == 6'b000101) begin
      c.alu_src_a = 1'b1;
      c.alu_op = 3'd1;
      c.pc_src = 2'b01;
      c.instr_done = 1'b1;
      c.branch = (op == 6'b000100);
      c.branch_ne = (op == 6'b000101);
      push(1'($urandom), c);
    end else if (op == 6'b001000 || op == 6'b001100 || op == 6'b001101 || op == 6'b001010) begin
      c.alu_src_a = 1'b1;
      c.alu_src_b = 2'b10;
      c.alu_op = op == 6'b001100 ? 3'd3 : op == 6'b001101 ? 3'd4 : op == 6'b001010 ? 3'd5 : 3'd0;
      c.zero_ext = (op == 6'b001100 || op == 6'b001101);
      push(1'($urandom), c);
      d = '0;
      d.reg_write = 1'b1;
      d.instr_done = 1'b1;
      d.zero_ext = c.zero_ext;
      push(1'($urandom), d);
    end else if (op == 6'b000010) begin
      c.pc_write = 1'b1;
      c.pc_src = 2'b10;
      c.instr_done = 1'b1;
      push(1'($urandom), c);
    end else begin
`ifdef ILLEGAL_TRAP_EN
      c.illegal = 1'b1;
      c.pc_write = 1'b1;
      c.pc_src = 2'b11;
      c.instr_done = 1'b1;
      push(1'($urandom), c);
`endif
    end
  endtask
  task automatic run(logic [5:0] op, int fw, int mw, int abort);
    build(op, fw, mw);
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      opcode = op;
      mem_ready = q[k].rdy;
      if (k == abort) begin
        reset = 1'b1;
        #1 check($sformatf("reset op%02h step%0d", op, k), 32'(got), 32'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        return;
      end
      #1 check($sformatf("op%02h fw%0d mw%0d step%0d", op, fw, mw, k), 32'(got), 32'(q[k].c));
    end
  endtask
  function automatic int rnd_wait();
    return ($urandom % 4 == 0) ? int'($urandom_range(0, TO + 1)) : 0;
  endfunction
  initial begin
    logic [5:0] ops [12];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000,
            6'b001100, 6'b001101, 6'b001010, 6'b000010, 6'b111111, 6'b010001};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      #1 check("in_reset", 32'(got), 32'(0));
    end
    @(posedge clk);
    #1 reset = 1'b0;
    run(6'b100011, 0, 0, -1);
    run(6'b101011, 0, 3, -1);
    run(6'b000101, 0, 0, -1);
    run(6'b001101, 0, 0, -1);
    run(6'b000000, 4, 0, -1);
    run(6'b100011, 3, 0, -1);
    run(6'b100011, 0, 4, -1);
    run(6'b101011, 0, 5, -1);
    run(6'b111111, 0, 0, -1);
    run(6'b101011, 0, 5, 4);
    run(6'b000100, 0, 0, -1);
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      op = ($urandom % 5 == 0) ? 6'($urandom) : ops[$urandom % 12];
      run(op, rnd_wait(), rnd_wait(), ($urandom % 8 == 0) ? int'($urandom_range(0, 7)) : -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
